// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// One request is outstanding at a time; every access waits LATENCY cycles before it commits.
module mem_responder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW          = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);
    localparam logic [3:0]  LAT_INIT    = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic            cap_we;
    logic            cap_err;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;
    logic [3:0]      cap_be;
    logic [31:0]     mem [MEM_DEPTH];

    logic accept_c;
    logic commit_c;
    logic req_err_c;

    assign accept_c  = req_valid && req_ready;
    assign commit_c  = (state == BUSY) && (wait_cnt == 4'd0);
    assign req_err_c = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_WORDS);

    // Request capture; the error decision is made once, at accept time.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            cap_we    <= req_we;
            cap_err   <= req_err_c;
            cap_idx   <= req_addr[AW+1:2];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Backing array: never reset, written only by a good write on its commit edge.
    always_ff @(posedge clk) begin
        if (!reset && commit_c && cap_we && !cap_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= BUSY;
                        req_ready <= 1'b0;
                        wait_cnt  <= LAT_INIT;
                    end
                end
                BUSY: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cap_err;
                        rsp_rdata <= (!cap_we && !cap_err) ? mem[cap_idx] : 32'd0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, is the number of 32-bit words in the backing array.
REQ-002 Parameter LATENCY, default 2, is the number of extra wait cycles before each access commits; legal range is 0..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address; word index is req_addr[31:2].
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte enables for writes; bit i enables byte lane i ([8i+7:8i]); ignored on reads.
REQ-011 rsp_valid  output  1  response is present.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and for errored requests.
REQ-014 rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
- Accept captures addr, we, wdata and be.
- Accept loads the wait counter with LATENCY.
- Accept moves the FSM to BUSY.
REQ-018 In BUSY, when the counter is nonzero, the counter SHALL decrement by 1 per cycle.
REQ-019 In BUSY, when the counter is 0, the access SHALL commit on that edge and the FSM SHALL move to RESP.
- Write: only the enabled byte lanes are updated.
- Read: the word is registered into rsp_rdata.
REQ-020 rsp_valid SHALL rise exactly LATENCY+1 cycles after the accept edge.
REQ-021 In RESP, the FSM SHALL stay in RESP with rsp_valid, rsp_rdata and rsp_err held stable until rsp_ready is 1; on that edge it SHALL return to IDLE.
REQ-022 The minimum spacing between two accepted requests SHALL be LATENCY+3 cycles; there is no overlap or pipelining of requests.
REQ-023 A request SHALL be flagged as an error (rsp_err = 1) in either of these cases:
- req_addr[1:0] != 0;
- req_addr[31:2] >= MEM_DEPTH.
REQ-024 An errored request SHALL leave the array unmodified, return rsp_rdata = 0, and use the same timing as a good request.
REQ-025 A write with req_be = 0000 SHALL complete normally, with rsp_err = 0 and no byte modified.
REQ-026 A read-after-write to the same address SHALL return the written data.
REQ-027 Inputs other than rsp_ready SHALL be ignored outside IDLE; a req_valid held high across BUSY and RESP SHALL be accepted only once the FSM has returned to IDLE.
REQ-028 The wait counter SHALL be 4 bits wide and SHALL NOT wrap or underflow.
REQ-029 Array contents SHALL be undefined at power-up; reads of never-written words return X in simulation.

Reset
REQ-030 While reset is 1, the FSM SHALL go to IDLE on the next edge, with these outputs: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
REQ-031 Reset SHALL NOT clear or modify array contents.
REQ-032 Reset asserted during BUSY SHALL abort the request; an uncommitted write SHALL NOT reach the array.
REQ-033 Reset asserted during RESP SHALL drop the response without a handshake.
REQ-034 Reset SHALL take priority over an accept or commit in the same cycle.

Verification
REQ-035 Write then read, LATENCY=2:
- Stimulus: write 0xDEADBEEF to address 0x10 with be=1111, then read 0x10.
- Response: each rsp_valid rises 3 cycles after its accept; read returns rsp_rdata = 0xDEADBEEF with rsp_err = 0.
REQ-036 Partial write:
- Stimulus: after REQ-035, write 0x0000AA00 to 0x10 with be=0010, then read 0x10.
- Response: rsp_rdata = 0xDEADAAEF.
REQ-037 Response backpressure:
- Stimulus: a read with rsp_ready held at 0 for 5 cycles.
- Response: rsp_valid and rsp_rdata stay stable, req_ready = 0 throughout, and the FSM returns to IDLE on the edge rsp_ready goes to 1.
REQ-038 Error cases:
- Stimulus: write to 0x13, then a read of 4*MEM_DEPTH, then a read of 0x10.
- Response: both faulty requests give rsp_err = 1 and rsp_rdata = 0; the final read still returns 0xDEADAAEF.
REQ-039 Reset mid-write:
- Stimulus: write 0x12345678 to 0x20 with LATENCY=4, then pulse reset one cycle after the accept.
- Response: rsp_valid never rises, req_ready = 1 after reset, and a subsequent read of 0x20 returns its prior contents.
REQ-040 LATENCY=0 back-to-back traffic:
- Stimulus: four writes followed by four reads, with req_valid held high and rsp_ready = 1.
- Response: a new accept every 3 cycles, and all reads return the written data.
